// File: rtl/misao_pkg.sv
// Shared definitions for the MISA-O core family: link-state codes,
// memory direction constants and the load/store unit state encoding.
package misao_pkg;

   // Link-state codes carried by the core; each selects a transfer width.
   localparam logic [1:0] UL   = 2'b00;
   localparam logic [1:0] LK8  = 2'b01;
   localparam logic [1:0] LK16 = 2'b10;

   // Memory port direction encoding for mem_rw.
   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Map a link-state code to the LSU's req_len (nibble count minus one).
   function automatic int unsigned link_to_len(input logic [1:0] link);
      case (link)
         LK8:     return 1;
         LK16:    return 3;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/misao_lsu.sv
// Nibble-serial load/store unit: moves 1..MAX_NIBBLES nibbles between an
// operand word and a narrow memory port, one nibble per req/ack handshake,
// little-endian, with optional sign extension of loads.
module misao_lsu
   import misao_pkg::*;
#(
   parameter int DATA_W      = 4,
   parameter int MAX_NIBBLES = 4,
   parameter int ADDR_W      = 16,
   parameter int LEN_W       = $clog2(MAX_NIBBLES)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic                          req_sext,
   input  logic [LEN_W-1:0]              req_len,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [MAX_NIBBLES*DATA_W-1:0] req_wdata,
   output logic                          rsp_valid,
   output logic [MAX_NIBBLES*DATA_W-1:0] rsp_rdata,
   output logic                          mem_req,
   input  logic                          mem_ack,
   output logic                          mem_rw,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_data_out,
   input  logic [DATA_W-1:0]             mem_data_in,
   output logic                          busy
);

   localparam int WORD_W = MAX_NIBBLES * DATA_W;

   lsu_state_t        state_reg, state_next;
   logic              write_reg, sext_reg;
   logic [LEN_W-1:0]  len_reg, idx_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [WORD_W-1:0] wdata_reg, buf_reg, rdata_reg, buf_next;
   logic              accept, last_nibble;

   // Zero- or sign-fill every nibble above len; the sign is the top bit of nibble len.
   function automatic logic [WORD_W-1:0] extend(input logic [WORD_W-1:0] data,
                                                 input logic [LEN_W-1:0]  len,
                                                 input logic              sext);
      logic [WORD_W-1:0] r;
      logic              sign;
      r    = data;
      sign = data[int'(len) * DATA_W + DATA_W - 1];
      for (int n = 0; n < MAX_NIBBLES; n++) begin
         if (n > int'(len))
            r[n*DATA_W +: DATA_W] = sext ? {DATA_W{sign}} : '0;
      end
      return r;
   endfunction

   assign accept      = req_valid && req_ready;
   assign last_nibble = (idx_reg == len_reg);

   // Read buffer with the incoming nibble merged at the current index.
   always_comb begin
      buf_next = buf_reg;
      buf_next[int'(idx_reg)*DATA_W +: DATA_W] = mem_data_in;
   end

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic: wait states simply hold XFER until mem_ack.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = XFER;
         XFER:    if (mem_ack && last_nibble) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request latch, nibble index, load buffer and registered load result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_reg <= 1'b0;
         sext_reg  <= 1'b0;
         len_reg   <= '0;
         idx_reg   <= '0;
         base_reg  <= '0;
         wdata_reg <= '0;
         buf_reg   <= '0;
         rdata_reg <= '0;
      end else if (state_reg == IDLE) begin
         if (accept) begin
            write_reg <= req_write;
            sext_reg  <= req_sext;
            len_reg   <= req_len;
            base_reg  <= req_addr;
            wdata_reg <= req_wdata;
            idx_reg   <= '0;
            buf_reg   <= '0;
         end
      end else if (state_reg == XFER && mem_ack) begin
         if (!write_reg) buf_reg <= buf_next;
         if (!last_nibble) idx_reg <= idx_reg + 1'b1;
         else if (!write_reg) rdata_reg <= extend(buf_next, len_reg, sext_reg);
      end
   end

   // Output decode; outside XFER the memory port parks at read/address 0/data 0.
   always_comb begin
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      mem_req      = 1'b0;
      mem_rw       = MEM_READ;
      mem_addr     = '0;
      mem_data_out = '0;
      case (state_reg)
         IDLE: req_ready = 1'b1;
         XFER: begin
            mem_req  = 1'b1;
            mem_rw   = write_reg ? MEM_WRITE : MEM_READ;
            mem_addr = base_reg + ADDR_W'(idx_reg);
            if (write_reg)
               mem_data_out = wdata_reg[int'(idx_reg)*DATA_W +: DATA_W];
         end
         DONE: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign busy      = !req_ready;
   assign rsp_rdata = rdata_reg;

endmodule
